// File: rtl/processor_help.sv
// rtl/processor_help.sv - shared processor word and bundle types
package processor_help;
  localparam int SUPER_SCALAR_WIDTH = 2;
  typedef logic [31:0] Word;
  typedef Word [SUPER_SCALAR_WIDTH-1:0] bundle_t;
endpackage

// File: rtl/fetch.sv
// rtl/fetch.sv - fetch stage: PC generation, imem bundle requests, in-order response buffer to decode
module fetch
  import processor_help::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_req_addr_out,
  input  logic        imem_resp_valid_in,
  input  bundle_t     imem_resp_data_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        decode_ready_in,
  output logic        decode_valid_out,
  output bundle_t     decode_data_out,
  output logic [31:0] decode_pc_out
);
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] STEP    = 32'(SUPER_SCALAR_WIDTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc, resp_pc;
  bundle_t       fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count, outstanding, drop_count;
  logic [CW:0]   in_use;
  logic          req_fire, resp_beat, push, pop;

  // Buffered plus in-flight bundles are capped at the fifo depth, so a push never finds it full.
  always_comb begin
    in_use             = {1'b0, fifo_count} + {1'b0, outstanding};
    imem_req_valid_out = !rst_in && !redirect_valid_in && (in_use < DEPTH_W);
    imem_req_addr_out  = pc;
    req_fire           = imem_req_valid_out && imem_req_ready_in;
    resp_beat          = imem_resp_valid_in && (outstanding != '0);
    push               = resp_beat && (drop_count == '0) && !redirect_valid_in;
    decode_valid_out   = !rst_in && (fifo_count != '0) && !redirect_valid_in;
    pop                = decode_valid_out && decode_ready_in;
    decode_data_out    = fifo_data[rd_ptr];
    decode_pc_out      = fifo_pc[rd_ptr];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_beat);
      if (redirect_valid_in) begin
        pc         <= redirect_pc_in;
        resp_pc    <= redirect_pc_in;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        // outstanding already covers beats marked for dropping, so every beat still in flight is stale
        drop_count <= outstanding - CW'(resp_beat);
      end else begin
        if (req_fire) pc <= pc + STEP;
        if (resp_beat && (drop_count != '0)) drop_count <= drop_count - 1'b1;
        if (push) begin
          resp_pc <= resp_pc + STEP;
          wr_ptr  <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_resp_data_in;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - scoreboard bench for fetch with a fixed-latency imem model
module tb_fetch;
  import processor_help::*;
  localparam int SSW = SUPER_SCALAR_WIDTH;

  logic        clk_in = 1'b0;
  logic        rst_in, imem_req_valid_out, imem_req_ready_in, imem_resp_valid_in;
  logic [31:0] imem_req_addr_out, redirect_pc_in, decode_pc_out;
  logic        redirect_valid_in, decode_ready_in, decode_valid_out;
  bundle_t     imem_resp_data_in, decode_data_out;

  always #5 clk_in = ~clk_in;

  fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .imem_req_valid_out(imem_req_valid_out), .imem_req_ready_in(imem_req_ready_in),
    .imem_req_addr_out(imem_req_addr_out), .imem_resp_valid_in(imem_resp_valid_in),
    .imem_resp_data_in(imem_resp_data_in), .redirect_valid_in(redirect_valid_in),
    .redirect_pc_in(redirect_pc_in), .decode_ready_in(decode_ready_in),
    .decode_valid_out(decode_valid_out), .decode_data_out(decode_data_out),
    .decode_pc_out(decode_pc_out)
  );

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [31:0] exp_q[$];
  int          pop_cyc_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          checks = 0, failures = 0, cyc = 0, lat = 1, n_acc = 0;
  chk_t        c;
  logic [31:0] e;

  function automatic bundle_t bundle_of(input logic [31:0] a);
    bundle_t     b;
    logic [31:0] ai;
    for (int i = 0; i < SSW; i++) begin
      ai   = a + 32'(i);
      b[i] = {ai[15:0] ^ 16'hC3A5, ~ai[15:0]};
    end
    return b;
  endfunction

  task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t k;
    k.name = name;
    k.act  = act;
    k.exp  = exp;
    chk_q.push_back(k);
  endtask

  task automatic step();
    @(posedge clk_in);
    cyc++;
    #1;
    if (!rst_in && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      imem_resp_valid_in = 1'b1;
      imem_resp_data_in  = bundle_of(pend_addr[0]);
    end else begin
      imem_resp_valid_in = 1'b0;
      imem_resp_data_in  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_in            = 1'b1;
    imem_req_ready_in = 1'b0;
    decode_ready_in   = 1'b0;
    redirect_valid_in = 1'b0;
    step();
    step();
    @(negedge clk_in);
    expect_eq("rst_req_valid", 64'(imem_req_valid_out), 64'd0);
    expect_eq("rst_dec_valid", 64'(decode_valid_out), 64'd0);
    step();
    rst_in = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) expect_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic int pop_at(input int idx);
    return (pop_cyc_q.size() > idx) ? pop_cyc_q[idx] : -1000;
  endfunction

  // imem model: fixed latency, in-order, keeps returning stale beats across redirects
  always @(negedge clk_in) begin
    if (rst_in) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (imem_resp_valid_in) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (imem_req_valid_out && imem_req_ready_in) begin
        pend_addr.push_back(imem_req_addr_out);
        pend_due.push_back(cyc + lat);
        n_acc++;
      end
    end
  end

  always @(negedge clk_in) begin
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        failures++;
        $display("FAIL %s actual=%0h required=%0h", c.name, c.act, c.exp);
      end
    end
    if (!rst_in && decode_valid_out && decode_ready_in) begin
      pop_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_bundle actual_pc=%0h required=none", decode_pc_out);
      end else begin
        e = exp_q.pop_front();
        if (decode_pc_out !== e || decode_data_out !== bundle_of(e)) begin
          failures++;
          $display("FAIL bundle actual_pc=%0h actual_data=%0h required_pc=%0h required_data=%0h",
                   decode_pc_out, decode_data_out, e, bundle_of(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s, a0, k;
    rst_in = 1'b1; imem_req_ready_in = 1'b0; imem_resp_valid_in = 1'b0; imem_resp_data_in = '0;
    redirect_valid_in = 1'b0; redirect_pc_in = '0; decode_ready_in = 1'b0;

    // streaming at latency 1: first bundle two cycles after reset release, then one per cycle
    do_reset();
    lat = 1; imem_req_ready_in = 1'b1; decode_ready_in = 1'b1;
    t0 = cyc; s = pop_cyc_q.size();
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(2 * i));
    @(negedge clk_in);
    expect_eq("t1_first_addr", 64'(imem_req_addr_out), 64'h0);
    expect_eq("t1_first_req_valid", 64'(imem_req_valid_out), 64'd1);
    drain(40);
    decode_ready_in = 1'b0;
    expect_eq("t1_first_latency", 64'(pop_at(s) - t0), 64'd2);
    expect_eq("t1_throughput", 64'(pop_at(s + 9) - pop_at(s)), 64'd9);

    // decode backpressure: exactly FIFO_DEPTH requests, then request valid drops
    do_reset();
    imem_req_ready_in = 1'b1; a0 = n_acc;
    repeat (10) step();
    @(negedge clk_in);
    expect_eq("t2_accepted", 64'(n_acc - a0), 64'd4);
    expect_eq("t2_req_valid", 64'(imem_req_valid_out), 64'd0);
    expect_eq("t2_dec_valid", 64'(decode_valid_out), 64'd1);
    expect_eq("t2_head_pc", 64'(decode_pc_out), 64'h0);
    step();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(2 * i));
    decode_ready_in = 1'b1;
    drain(40);
    decode_ready_in = 1'b0;

    // imem stall: address held while valid waits
    do_reset();
    decode_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      expect_eq("t3_hold_addr", 64'(imem_req_addr_out), 64'h0);
      expect_eq("t3_hold_valid", 64'(imem_req_valid_out), 64'd1);
      step();
    end
    imem_req_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(2 * i));
    @(negedge clk_in);
    expect_eq("t3_addr_at_accept", 64'(imem_req_addr_out), 64'h0);
    step();
    @(negedge clk_in);
    expect_eq("t3_addr_after_accept", 64'(imem_req_addr_out), 64'h2);
    drain(30);
    decode_ready_in = 1'b0;

    // redirect with two requests in flight at latency 3
    do_reset();
    lat = 3; imem_req_ready_in = 1'b1; decode_ready_in = 1'b1; a0 = n_acc; k = 0;
    while (n_acc - a0 < 2 && k < 10) begin
      step();
      k++;
    end
    expect_eq("t4_inflight", 64'(n_acc - a0), 64'd2);
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h100;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h100 + 32'(2 * i));
    @(negedge clk_in);
    expect_eq("t4_redir_req_valid", 64'(imem_req_valid_out), 64'd0);
    expect_eq("t4_redir_dec_valid", 64'(decode_valid_out), 64'd0);
    step();
    redirect_valid_in = 1'b0;
    drain(60);
    decode_ready_in = 1'b0;

    // redirect coinciding with a response beat and decode ready
    do_reset();
    lat = 1; imem_req_ready_in = 1'b1; decode_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(2 * i));
    drain(30);
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h200;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h200 + 32'(2 * i));
    @(negedge clk_in);
    expect_eq("t5_redir_dec_valid", 64'(decode_valid_out), 64'd0);
    step();
    redirect_valid_in = 1'b0;
    @(negedge clk_in);
    expect_eq("t5_empty_after", 64'(decode_valid_out), 64'd0);
    drain(30);
    decode_ready_in = 1'b0;

    // full fifo drained while refilling: pointers wrap several times without a gap
    do_reset();
    imem_req_ready_in = 1'b1;
    repeat (8) step();
    @(negedge clk_in);
    expect_eq("t6_full_valid", 64'(decode_valid_out), 64'd1);
    expect_eq("t6_full_req_valid", 64'(imem_req_valid_out), 64'd0);
    step();
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(2 * i));
    s = pop_cyc_q.size();
    decode_ready_in = 1'b1;
    drain(60);
    decode_ready_in = 1'b0;
    expect_eq("t6_no_gap", 64'(pop_at(s + 11) - pop_at(s)), 64'd11);

    step();
    @(negedge clk_in);
    step();
    @(negedge clk_in);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
